// File: rtl/cluster_clk_gate.sv
// Latch-based clock gate with hold-off window, test override and saturating suppressed-edge counter.
// Latency: an enable settled in the low phase governs the very next rising edge; no backpressure.
// Build option CLK_GATE_FPGA_BYPASS_EN: no latch, clk_o = clk, enable/counters still tracked.
module cluster_clk_gate #(
    parameter int HOLD_CYCLES = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 test_en_i,
    output logic                 clk_o,
    output logic                 clk_en_o,
    output logic [CNT_WIDTH-1:0] gated_cnt_o
);

    logic hold_active;
    logic en_eff;
    logic en_q;
    logic cnt_gate_en;

    assign en_eff = en_i | test_en_i | hold_active;

    generate
        if (HOLD_CYCLES > 0) begin : g_hold
            localparam int HW = $clog2(HOLD_CYCLES + 1);
            localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

            logic          en_prev_q;
            logic          en_prev_d;
            logic [HW-1:0] hold_cnt_q;
            logic [HW-1:0] hold_cnt_d;

            // A falling edge of en_i (re)loads the window, even mid-hold.
            always_comb begin
                en_prev_d  = en_i;
                hold_cnt_d = hold_cnt_q;
                if (en_prev_q && !en_i) begin
                    hold_cnt_d = HOLD_LOAD;
                end else if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    en_prev_q  <= 1'b0;
                    hold_cnt_q <= '0;
                end else begin
                    en_prev_q  <= en_prev_d;
                    hold_cnt_q <= hold_cnt_d;
                end
            end

            assign hold_active = (hold_cnt_q != '0);
        end else begin : g_no_hold
            assign hold_active = 1'b0;
        end
    endgenerate

`ifdef CLK_GATE_FPGA_BYPASS_EN
    logic en_d;

    assign en_d = en_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_d;
        end
    end

    // en_eff at the edge is what the ASIC latch would be holding, so counts line up.
    assign clk_o       = clk;
    assign clk_en_o    = rst_n ? en_q : test_en_i;
    assign cnt_gate_en = en_eff;
`else
    // Transparent in the low phase only, so clk_o pulses are never truncated.
    always_latch begin
        if (!rst_n) begin
            en_q <= test_en_i;
        end else if (!clk) begin
            en_q <= en_eff;
        end
    end

    assign clk_o       = clk & en_q;
    assign clk_en_o    = en_q;
    assign cnt_gate_en = en_q;
`endif

    logic [CNT_WIDTH-1:0] gated_cnt_q;
    logic [CNT_WIDTH-1:0] gated_cnt_d;

    always_comb begin
        gated_cnt_d = gated_cnt_q;
        if (!cnt_gate_en && (gated_cnt_q != '1)) begin
            gated_cnt_d = gated_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gated_cnt_q <= '0;
        end else begin
            gated_cnt_q <= gated_cnt_d;
        end
    end

    assign gated_cnt_o = gated_cnt_q;

endmodule

// File: tb/tb_cluster_clk_gate.sv
// Bench for cluster_clk_gate: three instances (no hold, 3-cycle hold, 4-bit counter) share one stimulus.
// Expected clk_o / clk_en_o / counts come from an edge-by-edge model of the gating rules.
module tb_cluster_clk_gate;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic en_i      = 1'b1;
    logic test_en_i = 1'b0;

    always #5 clk = ~clk;

    logic        clk_o0, clk_en0, clk_o3, clk_en3, clk_os, clk_ens;
    logic [15:0] cnt0, cnt3;
    logic [3:0]  cnts;

    cluster_clk_gate #(.HOLD_CYCLES(0), .CNT_WIDTH(16)) u_h0 (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .test_en_i(test_en_i),
        .clk_o(clk_o0), .clk_en_o(clk_en0), .gated_cnt_o(cnt0));

    cluster_clk_gate #(.HOLD_CYCLES(3), .CNT_WIDTH(16)) u_h3 (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .test_en_i(test_en_i),
        .clk_o(clk_o3), .clk_en_o(clk_en3), .gated_cnt_o(cnt3));

    cluster_clk_gate #(.HOLD_CYCLES(0), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .test_en_i(test_en_i),
        .clk_o(clk_os), .clk_en_o(clk_ens), .gated_cnt_o(cnts));

    logic        clko[3];
    logic        clken[3];
    logic [15:0] cntw[3];
    assign clko[0]  = clk_o0;
    assign clko[1]  = clk_o3;
    assign clko[2]  = clk_os;
    assign clken[0] = clk_en0;
    assign clken[1] = clk_en3;
    assign clken[2] = clk_ens;
    assign cntw[0]  = cnt0;
    assign cntw[1]  = cnt3;
    assign cntw[2]  = {12'd0, cnts};

    int p0 = 0;
    int p1 = 0;
    int p2 = 0;
    always @(posedge clk_o0) p0++;
    always @(posedge clk_o3) p1++;
    always @(posedge clk_os) p2++;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: edge index, index of last en_i falling edge, previous en_i, counts.
    int HOLD_N[3] = '{0, 3, 0};
    int CMAX[3]   = '{65535, 65535, 15};
    int m_edge    = 0;
    int m_fall[3] = '{-1000, -1000, -1000};
    bit m_prev[3] = '{1'b0, 1'b0, 1'b0};
    int m_cnt[3]  = '{0, 0, 0};
    int m_puls[3] = '{0, 0, 0};
    bit m_pass[3];

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s[inst %0d] at %0t: observed %0d, expected %0d", tag, idx, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = 0;
            m_fall[i] = -1000;
            m_prev[i] = 1'b0;
        end
    endtask

    // One clk period: inputs set early in the low phase, outputs checked mid high phase.
    task automatic step(input bit rst, input bit en, input bit test, input bit glitch);
        @(negedge clk);
        #1;
        rst_n     = rst;
        en_i      = en;
        test_en_i = test;
        for (int i = 0; i < 3; i++) check("clk_o_low", i, 32'(clko[i]), 32'd0);
        @(posedge clk);
        m_edge++;
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                model_reset();
                m_pass[i] = test;
            end else begin
                m_pass[i] = en | test | ((m_edge - m_fall[i]) <= HOLD_N[i]);
                if (!m_pass[i] && m_cnt[i] < CMAX[i]) m_cnt[i]++;
                if (m_prev[i] && !en) m_fall[i] = m_edge;
                m_prev[i] = en;
            end
            if (m_pass[i]) m_puls[i]++;
        end
        if (glitch) begin
            #1 en_i = ~en_i;
            #2;
        end else begin
            #3;
        end
        for (int i = 0; i < 3; i++) begin
            check("clk_o_high", i, 32'(clko[i]), 32'(m_pass[i]));
            check("clk_en_o", i, 32'(clken[i]), 32'(m_pass[i]));
            check("gated_cnt_o", i, 32'(cntw[i]), 32'(m_cnt[i]));
        end
    endtask

    task automatic check_pulses(input string tag);
        check(tag, 0, 32'(p0), 32'(m_puls[0]));
        check(tag, 1, 32'(p1), 32'(m_puls[1]));
        check(tag, 2, 32'(p2), 32'(m_puls[2]));
    endtask

    initial begin
        // Reset with en_i high and no test mode: everything quiet.
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("reset_cnt0_const", 0, 32'(cnt0), 32'd0);
        check("reset_pulses", 0, 32'(p0), 32'd0);

        // Release and run 5 enabled edges.
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("five_pulses_const", 0, 32'(p0), 32'd5);
        check_pulses("pulses_after_release");

        // Gate for 10 edges, then re-enable.
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("gated10_const", 0, 32'(cnt0), 32'd10);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_pulses("pulses_after_gating");

        // Enable changes in the high phase must not disturb the current pulse.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_pulses("pulses_after_glitch");

        // Hold-off window after a falling enable.
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0);
        check_pulses("pulses_after_hold");

        // Test mode, in and out of reset.
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b1, 1'b0);
        check("test_cnt_const", 0, 32'(cnt0), 32'd0);

        // Saturation of the 4-bit counter.
        repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("sat_const", 2, 32'(cnts), 32'd15);
        check_pulses("pulses_after_sat");

        // Reset in the middle of a high pulse cuts it immediately.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("midrst_clk_o", i, 32'(clko[i]), 32'd0);
            check("midrst_clk_en", i, 32'(clken[i]), 32'd0);
            check("midrst_cnt", i, 32'(cntw[i]), 32'd0);
        end
        model_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            bit r_rst, r_en, r_test, r_gl;
            r_rst  = ($urandom_range(0, 39) != 0);
            r_en   = ($urandom_range(0, 9) < 5);
            r_test = ($urandom_range(0, 9) == 0);
            r_gl   = ($urandom_range(0, 4) == 0);
            step(r_rst, r_en, r_test, r_gl);
        end
        check_pulses("pulses_after_random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion, expected completion before 200000");
        $fatal(1, "timeout");
    end

endmodule
